sub_16bit_seq: RTL and testbench
================================

# sub_16bit_seq

Sequential nibble-serial 16-bit subtractor: computes `a - b - bin` one SLICE-bit carry-lookahead slice per clock and returns the difference, borrow-out and signed overflow. It is the inverse-operation companion to the 16-bit CLA adder and uses the same operand and carry conventions with a borrow in place of a carry. Operands arrive on a valid/ready request channel and results leave on a valid/ready response channel, so the block sits between an operand source and a result consumer.

## Interface
- WIDTH, default 16: operand width; must be a multiple of SLICE.
- SLICE, default 4: bits processed per clock cycle.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start_valid  in  1  operand request valid.
- start_ready  out  1  block can accept operands; high only in IDLE.
- a  in  WIDTH  minuend; sampled on request handshake.
- b  in  WIDTH  subtrahend; sampled on request handshake.
- bin  in  1  borrow-in; sampled on request handshake.
- diff  out  WIDTH  result `a - b - bin`, modulo 2^WIDTH.
- bout  out  1  borrow-out; 1 when unsigned `a < b + bin`.
- ovf  out  1  two's-complement overflow of the subtraction.
- done_valid  out  1  diff, bout and ovf are valid.
- done_ready  in  1  consumer accepts the result.

## Operation
- Reset: state = IDLE.
  - start_ready = 1, done_valid = 0.
  - diff = 0, bout = 0, ovf = 0.
  - Internal operand, accumulator and counter registers = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready = 1.
  - If start_valid = 1: capture a, b, bin; set carry = ~bin; set slice counter k = 0; go to RUN.
- RUN:
  - Each cycle compute slice k as `{c, s} = a[k] + ~b[k] + carry`, a full SLICE-bit add using a lookahead carry.
  - Write s into accumulator slice k, set carry = c, then increment k.
  - When k = WIDTH/SLICE - 1, i.e. the last slice:
    - Load diff from the accumulator (last slice included).
    - bout = ~c.
    - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the captured operands.
    - Go to DONE.
- DONE:
  - done_valid = 1; diff, bout and ovf are held stable.
  - If done_ready = 1: go to IDLE.
- diff, bout and ovf change only on the RUN→DONE transition. They otherwise hold their last result, including after the response handshake.
- Input pins a, b and bin are ignored outside the IDLE handshake cycle. Changing them during RUN or DONE has no effect.
- start_valid asserted in RUN or DONE is ignored, not queued; start_ready is 0 in those states.
- Reset mid-operation (RUN or DONE): the operation is aborted immediately; done_valid is never raised for it; all outputs take their reset values.

## Timing
- Request handshake at edge E0 (start_valid && start_ready).
- Slices are computed at edges E1 … E(WIDTH/SLICE); with the defaults that is E1..E4.
- done_valid and the new results are visible after edge E(WIDTH/SLICE). Latency is 4 cycles at the defaults.
- Response handshake at the first edge Ed ≥ E5 where done_ready = 1. start_ready rises after Ed.
- Minimum request-to-request spacing is WIDTH/SLICE + 2 cycles (6 at the defaults), reached when done_ready is held high.
- No combinational path from any input to any output; start_ready and done_valid are decoded from the state register.

## Test plan
- Reset then 0 − 0 with bin = 1 → after 4 cycles, diff = 0xFFFF, bout = 1, ovf = 0.
- Basic subtraction, done_ready tied high:
  - 14 − 1 with bin = 1 → diff = 12, bout = 0, ovf = 0.
  - 999 − 0 with bin = 1 → diff = 998, bout = 0.
- Boundary values:
  - 0x8000 − 0x0001 with bin = 0 → diff = 0x7FFF, bout = 0, ovf = 1.
  - 0x0001 − 0x0002 with bin = 0 → diff = 0xFFFF, bout = 1, ovf = 0.
- Backpressure: 5 − 0 with bin = 0 and done_ready held low for 3 cycles → done_valid stays 1 and diff = 5 is stable the whole time; start_valid pulsed during DONE is ignored; start_ready = 1 only after done_ready is asserted.
- Operand churn: change a and b every cycle during RUN for 0x1234 − 0x0234 → diff = 0x1000.
- Reset during RUN at cycle 2, then 7 − 3 → no stale done_valid; the new result is diff = 4 after 4 cycles.

Source files
------------

// File: rtl/sub_16bit_seq.sv
// Nibble-serial subtractor: a - b - bin, one SLICE-bit lookahead slice per clock.
// Latency: WIDTH/SLICE cycles from request handshake to done_valid (4 at defaults).
// Backpressure: result held in DONE until done_ready; start_ready low outside IDLE.
module sub_16bit_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             done_valid,
  input  logic             done_ready
);

  localparam int NS = WIDTH / SLICE;
  localparam int KW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  // Operands are shifted right each RUN cycle so the active slice is always the low SLICE bits.
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Sign bits are kept separately because the shifters lose them before overflow is evaluated.
  logic             a_msb;
  logic             b_msb;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [KW-1:0]    k;

  logic [SLICE-1:0] sa;
  logic [SLICE-1:0] sb;
  logic [SLICE-1:0] g;
  logic [SLICE-1:0] p;
  logic [SLICE-1:0] s;
  logic [SLICE:0]   c;
  logic             pterm;
  logic             gterm;
  logic [WIDTH-1:0] acc_next;

  assign start_ready = (state == IDLE);
  assign done_valid  = (state == DONE);

  // Current slice: a + ~b + carry with every carry expanded in lookahead form.
  always_comb begin
    sa    = a_sh[SLICE-1:0];
    sb    = ~b_sh[SLICE-1:0];
    g     = sa & sb;
    p     = sa ^ sb;
    c     = '0;
    pterm = 1'b0;
    gterm = 1'b0;
    c[0]  = carry;
    for (int i = 0; i < SLICE; i++) begin
      pterm = carry;
      for (int j = 0; j <= i; j++) begin
        pterm = pterm & p[j];
      end
      c[i+1] = pterm;
      for (int j = 0; j <= i; j++) begin
        gterm = g[j];
        for (int m = j + 1; m <= i; m++) begin
          gterm = gterm & p[m];
        end
        c[i+1] = c[i+1] | gterm;
      end
    end
    s = p ^ c[SLICE-1:0];
    // New slice enters at the top; after NS slices the accumulator is in natural bit order.
    acc_next = acc >> SLICE;
    acc_next[WIDTH-1 -: SLICE] = s;
  end

  // Control FSM plus operand, accumulator and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      acc   <= '0;
      carry <= 1'b0;
      k     <= '0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            carry <= ~bin;
            k     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> SLICE;
          b_sh  <= b_sh >> SLICE;
          acc   <= acc_next;
          carry <= c[SLICE];
          k     <= k + KW'(1);
          if (k == K_LAST) begin
            diff  <= acc_next;
            bout  <= ~c[SLICE];
            ovf   <= (a_msb != b_msb) && (acc_next[WIDTH-1] != a_msb);
            k     <= '0;
            state <= DONE;
          end
        end
        DONE: begin
          if (done_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_16bit_seq.sv
// Self-checking bench for sub_16bit_seq: table vectors, corner sequences, random ops.
// Expected results come from constants and an integer-arithmetic reference model.
// Results are consumed with done_ready stalls to exercise the response channel.
module tb_sub_16bit_seq;

  logic        clk;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;
  logic        done_valid;
  logic        done_ready;

  int checks;
  int errors;

  sub_16bit_seq #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk),
    .rst(rst),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .a(a),
    .b(b),
    .bin(bin),
    .diff(diff),
    .bout(bout),
    .ovf(ovf),
    .done_valid(done_valid),
    .done_ready(done_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] d;
    logic        bo;
    logic        ov;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned for borrow and signed for overflow.
  task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic mbin,
                       output logic [15:0] d, output logic bo, output logic ov);
    int ur;
    int sr;
    ur = int'(ma) - int'(mb) - int'(mbin);
    sr = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
    d  = ur[15:0];
    bo = (ur < 0);
    ov = (sr > 32767) || (sr < -32768);
  endtask

  // Handshake one request, then churn the operand pins until done_valid (bounded).
  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic ibin,
                        output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!start_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    a = ia;
    b = ib;
    bin = ibin;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    lat = 0;
    while (!done_valid && lat < 20) begin
      a   = 16'($urandom);
      b   = 16'($urandom);
      bin = 1'($urandom);
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Hold the result for 'stall' cycles, then accept it and check the return to IDLE.
  task automatic consume(input string name, input logic [15:0] exp_d, input int stall);
    logic held;
    held = 1'b1;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      if (!(done_valid && !start_ready && diff == exp_d)) held = 1'b0;
    end
    if (stall > 0) check({name, " held"}, {31'd0, held}, 32'd1);
    done_ready = 1'b1;
    @(posedge clk);
    #1;
    done_ready = 1'b0;
    check({name, " ready after"}, {30'd0, start_ready, done_valid}, 32'b10);
    check({name, " diff kept"}, {16'd0, diff}, {16'd0, exp_d});
  endtask

  initial begin
    int lat;
    logic [15:0] ed;
    logic eb;
    logic eo;
    logic ok;
    logic [15:0] ra;
    logic [15:0] rb;
    logic rbin;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    start_valid = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    done_ready = 1'b0;

    vecs[0] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[1] = '{16'd14,   16'd1,    1'b1, 16'd12,   1'b0, 1'b0};
    vecs[2] = '{16'd999,  16'd0,    1'b1, 16'd998,  1'b0, 1'b0};
    vecs[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vecs[4] = '{16'h0001, 16'h0002, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[5] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[6] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};

    #12;
    check("reset ready/valid", {30'd0, start_ready, done_valid}, 32'b10);
    check("reset diff", {16'd0, diff}, 32'd0);
    check("reset bout/ovf", {30'd0, bout, ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table vectors.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, lat);
      check($sformatf("vec%0d latency", i), lat, 32'd4);
      check($sformatf("vec%0d diff", i), {16'd0, diff}, {16'd0, vecs[i].d});
      check($sformatf("vec%0d bout", i), {31'd0, bout}, {31'd0, vecs[i].bo});
      check($sformatf("vec%0d ovf", i), {31'd0, ovf}, {31'd0, vecs[i].ov});
      consume($sformatf("vec%0d", i), vecs[i].d, i % 2);
    end

    // Backpressure: result held for 3 cycles while a stray start_valid is ignored.
    run_op(16'd5, 16'd0, 1'b0, lat);
    check("bp latency", lat, 32'd4);
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 16'hABCD;
      b = 16'h0001;
      start_valid = (i == 1);
      @(posedge clk);
      #1;
      if (!(done_valid && !start_ready && diff == 16'd5 && !bout && !ovf)) ok = 1'b0;
    end
    start_valid = 1'b0;
    check("bp held", {31'd0, ok}, 32'd1);
    done_ready = 1'b1;
    @(posedge clk);
    #1;
    done_ready = 1'b0;
    check("bp release", {30'd0, start_ready, done_valid}, 32'b10);
    check("bp diff after", {16'd0, diff}, 32'd5);
    // The stray request must not have started anything.
    repeat (3) @(posedge clk);
    #1;
    check("bp no queued op", {30'd0, start_ready, done_valid}, 32'b10);

    // Reset in the middle of RUN aborts the operation.
    @(negedge clk);
    a = 16'd9;
    b = 16'd2;
    bin = 1'b0;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst ready/valid", {30'd0, start_ready, done_valid}, 32'b10);
    check("midrst diff", {16'd0, diff}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ok = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done_valid) ok = 1'b0;
    end
    check("midrst no stale valid", {31'd0, ok}, 32'd1);
    run_op(16'd7, 16'd3, 1'b0, lat);
    check("after rst latency", lat, 32'd4);
    check("after rst diff", {16'd0, diff}, 32'd4);
    check("after rst bout/ovf", {30'd0, bout, ovf}, 32'd0);
    consume("after rst", 16'd4, 0);

    // Random operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rbin = 1'($urandom);
      if (i % 5 == 0) rb = ra;
      if (i % 7 == 0) ra = 16'h8000;
      model(ra, rb, rbin, ed, eb, eo);
      run_op(ra, rb, rbin, lat);
      check($sformatf("rnd%0d latency", i), lat, 32'd4);
      check($sformatf("rnd%0d %h-%h-%0d", i, ra, rb, rbin),
            {13'd0, bout, ovf, 1'b0, diff}, {13'd0, eb, eo, 1'b0, ed});
      consume($sformatf("rnd%0d", i), ed, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
